// File: rtl/peak_window_sched.sv
// Peak-magnitude window monitor for the DDC output lanes.
// Each lane registers |x| (one's-complement style) and tracks its running peak
// for the current window. At every window boundary all lane peaks are snapshotted
// and streamed out channel by channel over a valid/ready port.

// Per-lane magnitude register and peak accumulator.
module peak_window_lane #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [DW-1:0] x,
  input  logic          mvld,
  input  logic          strobe,
  output logic [DW-1:0] inner
);
  logic [DW-1:0] mag_d, mag_q;
  logic [DW-1:0] inner_d, inner_q;

  // Magnitude: invert the low bits of negative samples so the most negative code saturates.
  always_comb begin
    mag_d = x[DW-1] ? {1'b0, ~x[DW-2:0]} : x;
  end

  // Peak update; the boundary restarts the peak from this cycle's stage-1 sample.
  always_comb begin
    inner_d = inner_q;
    if (!enable)
      inner_d = '0;
    else if (strobe)
      inner_d = mvld ? mag_q : '0;
    else if (mvld && (mag_q > inner_q))
      inner_d = mag_q;
  end

  // Lane state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_q   <= '0;
      inner_q <= '0;
    end else begin
      mag_q   <= mag_d;
      inner_q <= inner_d;
    end
  end

  assign inner = inner_q;
endmodule

module peak_window_sched #(
  parameter int NCH   = 4,
  parameter int DW    = 32,
  parameter int WIN_W = 24,
  parameter int CH_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [WIN_W-1:0]  win_len,
  input  logic [NCH*DW-1:0] din,
  input  logic              din_vld,
  output logic              win_pulse,
  output logic [DW-1:0]     pk_data,
  output logic [CH_W-1:0]   pk_ch,
  output logic              pk_vld,
  input  logic              pk_rdy,
  output logic              overrun
);
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [WIN_W-1:0]         cnt_q, cnt_d, len_q, len_d, len_eff, win_clamp;
  logic                     pulse_c, pulse_q, mvld_q, mvld_d;
  logic [NCH-1:0][DW-1:0]   inner, shadow_q, shadow_d;
  logic [CH_W-1:0]          ch_q, ch_d;
  logic                     overrun_q, overrun_d;
  logic                     strobe, hs, last;

  // Window timer: length is sampled at the start of each window, min 2.
  always_comb begin
    win_clamp = (win_len < WIN_W'(2)) ? WIN_W'(2) : win_len;
    len_eff   = (cnt_q == '0) ? win_clamp : len_q;
    pulse_c   = enable && (cnt_q == len_eff - WIN_W'(1));
    len_d     = (enable && cnt_q == '0) ? win_clamp : len_q;
    if (!enable || pulse_c)
      cnt_d = '0;
    else
      cnt_d = cnt_q + WIN_W'(1);
    mvld_d = enable & din_vld;
  end

  // Timer, pipelined valid and delayed boundary strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      len_q   <= '0;
      pulse_q <= 1'b0;
      mvld_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      pulse_q <= pulse_c;
      mvld_q  <= mvld_d;
    end
  end

  assign win_pulse = pulse_c;
  assign strobe    = pulse_q;

  genvar k;
  generate
    for (k = 0; k < NCH; k++) begin : g_lane
      peak_window_lane #(.DW(DW)) u_lane (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .x      (din[k*DW +: DW]),
        .mvld   (mvld_q),
        .strobe (strobe),
        .inner  (inner[k])
      );
    end
  endgenerate

  assign hs   = (state_q == SEND) && pk_rdy;
  assign last = (ch_q == CH_W'(NCH-1));

  // Readout state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Readout next state; a strobe on the final beat chains straight into a new frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (strobe) state_d = SEND;
      SEND: if (hs && last && !strobe) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Snapshot capture, channel walk and sticky overrun.
  always_comb begin
    shadow_d  = shadow_q;
    ch_d      = ch_q;
    overrun_d = overrun_q;
    if (state_q == IDLE) begin
      if (strobe) begin
        shadow_d = inner;
        ch_d     = '0;
      end
    end else if (hs) begin
      if (last) begin
        ch_d = '0;
        if (strobe) shadow_d = inner;
      end else begin
        ch_d = ch_q + CH_W'(1);
      end
    end
    if ((state_q == SEND) && strobe && !(hs && last))
      overrun_d = 1'b1;
    if (!enable)
      overrun_d = 1'b0;
  end

  // Readout datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q  <= '0;
      ch_q      <= '0;
      overrun_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      ch_q      <= ch_d;
      overrun_q <= overrun_d;
    end
  end

  // Outputs are forced to zero outside SEND so reset drops them immediately.
  always_comb begin
    pk_vld  = (state_q == SEND);
    pk_data = pk_vld ? shadow_q[ch_q] : '0;
    pk_ch   = pk_vld ? ch_q : '0;
    overrun = overrun_q;
  end
endmodule
